// File: rtl/adder_eval_pkg.sv
// Shared types and helpers for evaluating the BCSA approximate adder:
// monitor FSM states, default widths and the error-distance function.
package adder_eval_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACC_W = 32;
  localparam int ED_W      = DEF_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  // |a - b| on sum-plus-carry values; one extra sign bit keeps the difference exact.
  function automatic logic [ED_W-1:0] abs_diff(input logic [ED_W-1:0] a,
                                               input logic [ED_W-1:0] b);
    logic signed [ED_W:0] diff;
    logic        [ED_W:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[ED_W] ? $unsigned(-diff) : $unsigned(diff);
    return mag[ED_W-1:0];
  endfunction

endpackage

// File: rtl/adder_error_monitor_err_dist_stage.sv
// Two-stage error-distance pipeline: registers the exact and approximate sums
// of an accepted sample, then registers their absolute difference.
module err_dist_stage
  import adder_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] s,
  input  logic             co,
  output logic             vld_p1,
  output logic             vld_p2,
  output logic [WIDTH:0]   ed_p2
);

  logic [WIDTH:0] exact_p1_d, exact_p1_q;
  logic [WIDTH:0] approx_p1_d, approx_p1_q;
  logic           vld_p1_d, vld_p1_q;
  logic [WIDTH:0] ed_p2_d, ed_p2_q;
  logic           vld_p2_d, vld_p2_q;

  always_comb begin
    // Stage 1: exact reference sum and approximate result, held between samples
    exact_p1_d  = exact_p1_q;
    approx_p1_d = approx_p1_q;
    vld_p1_d    = in_vld;
    if (in_vld) begin
      exact_p1_d  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      approx_p1_d = {co, s};
    end
    // Stage 2: error distance
    ed_p2_d  = ed_p2_q;
    vld_p2_d = vld_p1_q;
    if (vld_p1_q) begin
      ed_p2_d = abs_diff(exact_p1_q, approx_p1_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exact_p1_q  <= '0;
      approx_p1_q <= '0;
      vld_p1_q    <= 1'b0;
      ed_p2_q     <= '0;
      vld_p2_q    <= 1'b0;
    end else begin
      exact_p1_q  <= exact_p1_d;
      approx_p1_q <= approx_p1_d;
      vld_p1_q    <= vld_p1_d;
      ed_p2_q     <= ed_p2_d;
      vld_p2_q    <= vld_p2_d;
    end
  end

  assign vld_p1 = vld_p1_q;
  assign vld_p2 = vld_p2_q;
  assign ed_p2  = ed_p2_q;

endmodule

// File: rtl/adder_error_monitor.sv
// Accuracy monitor for the BCSA approximate adder: over a window of N accepted
// samples it counts erroneous results and accumulates sum/max error distance.
module adder_error_monitor
  import adder_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_I,
  input  logic [WIDTH-1:0] B_I,
  input  logic             Co_Iin,
  input  logic [WIDTH-1:0] S_I,
  input  logic             Co_I,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_err_dist,
  output logic [WIDTH:0]   max_err_dist,
  output logic [CNT_W-1:0] sample_count
);

  mon_state_e     state_d, state_q;
  logic [CNT_W-1:0] num_d, num_q;
  logic [CNT_W-1:0] sample_count_d, sample_count_q;
  logic [CNT_W-1:0] err_count_d, err_count_q;
  logic [ACC_W-1:0] sum_err_d, sum_err_q;
  logic [WIDTH:0]   max_err_d, max_err_q;
  logic [CNT_W-1:0] sample_inc;

  logic           accept;
  logic           vld_p1;
  logic           vld_p2;
  logic [WIDTH:0] ed_p2;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [WIDTH:0]   inc);
    logic [ACC_W:0] total;
    total = {1'b0, acc} + {{(ACC_W - WIDTH){1'b0}}, inc};
    return total[ACC_W] ? {ACC_W{1'b1}} : total[ACC_W-1:0];
  endfunction

  assign in_ready   = (state_q == RUN);
  assign accept     = in_valid && in_ready;
  assign sample_inc = sample_count_q + CNT_W'(1);

  err_dist_stage #(
    .WIDTH (WIDTH)
  ) u_err_dist_stage (
    .clk    (clk),
    .rst    (rst),
    .in_vld (accept),
    .a      (A_I),
    .b      (B_I),
    .cin    (Co_Iin),
    .s      (S_I),
    .co     (Co_I),
    .vld_p1 (vld_p1),
    .vld_p2 (vld_p2),
    .ed_p2  (ed_p2)
  );

  always_comb begin
    state_d        = state_q;
    num_d          = num_q;
    sample_count_d = sample_count_q;
    err_count_d    = err_count_q;
    sum_err_d      = sum_err_q;
    max_err_d      = max_err_q;

    // Accumulate: stage-2 result folds into the window statistics
    if (vld_p2) begin
      if (ed_p2 != '0) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
      sum_err_d = sat_add(sum_err_q, ed_p2);
      if (ed_p2 > max_err_q) begin
        max_err_d = ed_p2;
      end
    end

    case (state_q)
      IDLE, DONE: begin
        // The pipeline is empty here, so a start can safely clear everything.
        if (start) begin
          num_d          = num_samples;
          sample_count_d = '0;
          err_count_d    = '0;
          sum_err_d      = '0;
          max_err_d      = '0;
          state_d        = (num_samples != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (accept) begin
          sample_count_d = sample_inc;
          if (sample_inc == num_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!vld_p1 && !vld_p2) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      num_q          <= '0;
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_err_q      <= '0;
      max_err_q      <= '0;
    end else begin
      state_q        <= state_d;
      num_q          <= num_d;
      sample_count_q <= sample_count_d;
      err_count_q    <= err_count_d;
      sum_err_q      <= sum_err_d;
      max_err_q      <= max_err_d;
    end
  end

  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign err_count    = err_count_q;
  assign sum_err_dist = sum_err_q;
  assign max_err_dist = max_err_q;
  assign sample_count = sample_count_q;

endmodule
